// File: rtl/snax_reshuffler_feed_buffer.sv
// snax_reshuffler_feed_buffer: job-gated elastic FIFO from the streamer to the data reshuffler.
// Ports:
//   clock, reset                   clock and asynchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o    beat stream from the streamer
//   out_data_o/out_valid_o/out_ready_i beat stream to the reshuffler
//   ctrl_beats_i/ctrl_valid_i/ctrl_ready_o  job length CSR write
//   busy_o, beat_count_o, stall_count_o     read-only status CSRs
module snax_reshuffler_feed_buffer #(
    parameter int DataWidth = 512,
    parameter int Depth     = 4,
    parameter int CntWidth  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic [CntWidth-1:0]  ctrl_beats_i,
    input  logic                 ctrl_valid_i,
    output logic                 ctrl_ready_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  beat_count_o,
    output logic [CntWidth-1:0]  stall_count_o
);
    localparam int AW = $clog2(Depth);
    localparam int OW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_next;
    logic [DataWidth-1:0]  mem [Depth];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [OW-1:0]         count;
    logic [CntWidth-1:0]   rem_in, rem_out, beat_cnt, stall_cnt;
    logic                  push, pop, stall, ctrl_fire;

    // Ready depends only on registered occupancy: no write-through when full.
    assign in_ready_o    = (state == RUN) && (rem_in != '0) && (count != OW'(Depth));
    assign out_valid_o   = count != '0;
    assign out_data_o    = mem[rd_ptr];
    assign ctrl_ready_o  = state == IDLE;
    assign busy_o        = state == RUN;
    assign beat_count_o  = beat_cnt;
    assign stall_count_o = stall_cnt;
    assign push          = in_valid_i && in_ready_o;
    assign pop           = out_valid_o && out_ready_i;
    assign stall         = (state == RUN) && out_valid_o && !out_ready_i;
    assign ctrl_fire     = ctrl_ready_o && ctrl_valid_i;

    always_comb begin
        state_next = state;
        if (state == IDLE && ctrl_fire && ctrl_beats_i != '0)
            state_next = RUN;
        // Every pushed beat precedes its pop, so the FIFO is empty on the last pop.
        else if (state == RUN && pop && rem_out == CntWidth'(1))
            state_next = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rem_in    <= '0;
            rem_out   <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < Depth; i++)
                mem[i] <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                mem[wr_ptr] <= in_data_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + OW'(push) - OW'(pop);
            if (ctrl_fire) begin
                rem_in    <= ctrl_beats_i;
                rem_out   <= ctrl_beats_i;
                beat_cnt  <= '0;
                stall_cnt <= '0;
            end else begin
                if (push)
                    rem_in <= rem_in - CntWidth'(1);
                if (pop) begin
                    rem_out  <= rem_out - CntWidth'(1);
                    beat_cnt <= beat_cnt + CntWidth'(beat_cnt != '1);
                end
                if (stall)
                    stall_cnt <= stall_cnt + CntWidth'(stall_cnt != '1);
            end
        end
    end
endmodule

// File: tb/tb_snax_reshuffler_feed_buffer.sv
// tb_snax_reshuffler_feed_buffer: scoreboard bench for the reshuffler feed buffer.
module tb_snax_reshuffler_feed_buffer;
    localparam int DW = 512;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] ctrl_beats_i = '0;
    logic          ctrl_valid_i = 1'b0;
    logic          ctrl_ready_o;
    logic          busy_o;
    logic [CW-1:0] beat_count_o;
    logic [CW-1:0] stall_count_o;

    snax_reshuffler_feed_buffer dut (
        .clock(clock), .reset(reset),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .ctrl_beats_i(ctrl_beats_i), .ctrl_valid_i(ctrl_valid_i), .ctrl_ready_o(ctrl_ready_o),
        .busy_o(busy_o), .beat_count_o(beat_count_o), .stall_count_o(stall_count_o)
    );

    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    int            model_stall = 0;
    logic [DW-1:0] src [$];
    logic [DW-1:0] exp_q [$];
    bit            in_hs = 1'b0;
    bit            in_rand = 1'b0;
    bit            out_rand = 1'b0;
    bit            out_hold = 1'b1;

    function automatic logic [DW-1:0] beat(input int jid, input int idx);
        logic [31:0] w;
        w = {jid[15:0], idx[15:0]};
        return {16{w}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each output handshake.
    always @(negedge clock) begin
        in_hs = in_valid_i && in_ready_o;
        if (!reset && busy_o && out_valid_o && !out_ready_i)
            model_stall++;
        if (!reset && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h expected none", out_data_o);
            end else
                check("beat_data", out_data_o, exp_q.pop_front());
        end
    end

    // Streamer and reshuffler drivers.
    always @(posedge clock) begin
        #1;
        if (in_hs && src.size() > 0)
            void'(src.pop_front());
        in_valid_i  = (src.size() > 0) && (!in_rand || $urandom_range(0, 1) == 1);
        in_data_i   = (src.size() > 0) ? src[0] : '0;
        out_ready_i = out_rand ? ($urandom_range(0, 1) == 1) : out_hold;
    end

    task automatic start_job(input int n, input int offer, input int jid);
        for (int i = 0; i < offer; i++) begin
            src.push_back(beat(jid, i));
            if (i < n)
                exp_q.push_back(beat(jid, i));
        end
        @(posedge clock); #1;
        ctrl_beats_i = n;
        ctrl_valid_i = 1'b1;
        @(posedge clock); #1;
        ctrl_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (busy_o && k < budget);
        if (busy_o) begin
            tests++;
            fails++;
            $display("FAIL job_timeout: busy still 1 after %0d cycles, required 0", k);
        end
    endtask

    initial begin
        int k;
        @(negedge clock);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_ctrl_ready", ctrl_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_beat_count", beat_count_o, 0);
        check("rst_stall_count", stall_count_o, 0);
        @(posedge clock); #1 reset = 1'b0;

        // 8-beat job, free-flowing
        start_job(8, 8, 1);
        @(negedge clock);
        check("t1_busy", busy_o, 1);
        check("t1_ctrl_ready", ctrl_ready_o, 0);
        check("t1_no_early_out", out_valid_o, 0);
        @(negedge clock);
        check("t1_first_valid", out_valid_o, 1);
        check("t1_first_data", out_data_o, beat(1, 0));
        wait_idle(50);
        check("t1_beats", beat_count_o, 8);
        check("t1_stalls", stall_count_o, 0);
        check("t1_drained", exp_q.size(), 0);

        // 6-beat job against a stalled reshuffler
        out_hold = 1'b0;
        start_job(6, 6, 2);
        k = 0;
        while (stall_count_o != 9 && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("t2_stall9", stall_count_o, 9);
        check("t2_full_in_ready", in_ready_o, 0);
        check("t2_pushes", 6 - src.size(), 4);
        check("t2_out_valid", out_valid_o, 1);
        out_hold = 1'b1;
        @(negedge clock);
        check("t2_stall10", stall_count_o, 10);
        wait_idle(50);
        check("t2_beats", beat_count_o, 6);
        check("t2_stalls", stall_count_o, 10);
        check("t2_drained", exp_q.size(), 0);

        // 3-beat job, streamer offers 5
        start_job(3, 5, 3);
        wait_idle(50);
        repeat (2) @(negedge clock);
        check("t3_beats", beat_count_o, 3);
        check("t3_in_ready", in_ready_o, 0);
        check("t3_pending", src.size(), 2);
        check("t3_pending_valid", in_valid_i, 1);
        check("t3_drained", exp_q.size(), 0);
        src.delete();

        // zero-length job clears counters
        start_job(0, 0, 4);
        @(negedge clock);
        check("t4_busy", busy_o, 0);
        check("t4_beats", beat_count_o, 0);
        check("t4_stalls", stall_count_o, 0);
        check("t4_in_ready", in_ready_o, 0);
        check("t4_ctrl_ready", ctrl_ready_o, 1);

        // ctrl write during RUN is ignored
        out_hold = 1'b0;
        start_job(4, 4, 5);
        @(posedge clock); #1;
        ctrl_beats_i = 7;
        ctrl_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("t5_ctrl_ready", ctrl_ready_o, 0);
        end
        @(posedge clock); #1;
        ctrl_valid_i = 1'b0;
        out_hold = 1'b1;
        wait_idle(50);
        repeat (2) @(negedge clock);
        check("t5_beats", beat_count_o, 4);
        check("t5_idle_in_ready", in_ready_o, 0);
        check("t5_busy", busy_o, 0);
        start_job(2, 2, 6);
        wait_idle(50);
        check("t5_new_job_beats", beat_count_o, 2);
        check("t5_drained", exp_q.size(), 0);

        // 100-beat job with random handshakes
        in_rand = 1'b1;
        out_rand = 1'b1;
        model_stall = 0;
        start_job(100, 100, 9);
        wait_idle(3000);
        in_rand = 1'b0;
        out_rand = 1'b0;
        check("t6_beats", beat_count_o, 100);
        check("t6_stalls", stall_count_o, model_stall);
        check("t6_drained", exp_q.size(), 0);

        // asynchronous reset with 3 beats buffered
        out_hold = 1'b0;
        start_job(3, 3, 10);
        repeat (6) @(negedge clock);
        check("t7_pre_valid", out_valid_o, 1);
        check("t7_pre_stalling", stall_count_o != 0, 1);
        #2 reset = 1'b1;
        #1;
        check("t7_out_valid", out_valid_o, 0);
        check("t7_out_data", out_data_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_ctrl_ready", ctrl_ready_o, 1);
        check("t7_beats", beat_count_o, 0);
        check("t7_stalls", stall_count_o, 0);
        exp_q.delete();
        src.delete();
        out_hold = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // fresh 2-beat job after reset
        start_job(2, 2, 11);
        wait_idle(50);
        repeat (2) @(negedge clock);
        check("t8_beats", beat_count_o, 2);
        check("t8_out_valid", out_valid_o, 0);
        check("t8_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
